// File: rtl/decode_stage.sv
// decode_stage: IF/ID latch, field split, 32x32 register file,
// immediate extension and ID/EX output register.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic [31:0] PCNext,
  input  logic        stall,
  input  logic        flush,
  input  logic        WrEn,
  input  logic [4:0]  WrAddr,
  input  logic [31:0] WrData,
  output logic        ValidE,
  output logic [31:0] PCNextE,
  output logic [31:0] RsDataE,
  output logic [31:0] RtDataE,
  output logic [31:0] ImmE,
  output logic [5:0]  OpE,
  output logic [5:0]  FunctE,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE,
  output logic [4:0]  ShamtE
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pcnext;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pcnext;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic [31:0] imm;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } id_ex_t;

  if_id_t      d;
  id_ex_t      ex;
  id_ex_t      nx;
  logic [31:0] rf [32];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm16;
  logic        wr_ok;

  assign op    = d.inst[31:26];
  assign rs    = d.inst[25:21];
  assign rt    = d.inst[20:16];
  assign imm16 = d.inst[15:0];
  assign wr_ok = WrEn && (WrAddr != 5'd0);

  // IF/ID: flush beats stall, stall holds, else load from fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d <= '0;
    end else if (flush) begin
      d <= '0;
    end else if (!stall) begin
      d.inst   <= Inst;
      d.pcnext <= PCNext;
      d.valid  <= 1'b1;
    end
  end

  // register file write port; $0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (wr_ok) begin
      rf[WrAddr] <= WrData;
    end
  end

  // decode: fields, operand reads with write-through, immediate
  always_comb begin
    nx        = '0;
    nx.valid  = d.valid;
    nx.pcnext = d.pcnext;
    nx.op     = op;
    nx.rs     = rs;
    nx.rt     = rt;
    nx.rd     = d.inst[15:11];
    nx.shamt  = d.inst[10:6];
    nx.funct  = d.inst[5:0];

    unique case (1'b1)
      (rs == 5'd0):             nx.rsdata = '0;
      (wr_ok && WrAddr == rs):  nx.rsdata = WrData;
      default:                  nx.rsdata = rf[rs];
    endcase

    unique case (1'b1)
      (rt == 5'd0):             nx.rtdata = '0;
      (wr_ok && WrAddr == rt):  nx.rtdata = WrData;
      default:                  nx.rtdata = rf[rt];
    endcase

    unique case (1'b1)
      (op == 6'h0C),
      (op == 6'h0D),
      (op == 6'h0E): nx.imm = {16'h0, imm16};
      (op == 6'h0F): nx.imm = {imm16, 16'h0};
      default:       nx.imm = {{16{imm16[15]}}, imm16};
    endcase
  end

  // ID/EX: stall injects a bubble, flush leaves this slot alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex <= '0;
    end else if (stall) begin
      ex <= '0;
    end else begin
      ex <= nx;
    end
  end

  assign ValidE  = ex.valid;
  assign PCNextE = ex.pcnext;
  assign RsDataE = ex.rsdata;
  assign RtDataE = ex.rtdata;
  assign ImmE    = ex.imm;
  assign OpE     = ex.op;
  assign FunctE  = ex.funct;
  assign RsE     = ex.rs;
  assign RtE     = ex.rt;
  assign RdE     = ex.rd;
  assign ShamtE  = ex.shamt;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage
// against an arithmetic model of the decode rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst;
  logic [31:0] PCNext;
  logic        stall;
  logic        flush;
  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [31:0] WrData;
  logic        ValidE;
  logic [31:0] PCNextE;
  logic [31:0] RsDataE;
  logic [31:0] RtDataE;
  logic [31:0] ImmE;
  logic [5:0]  OpE;
  logic [5:0]  FunctE;
  logic [4:0]  RsE;
  logic [4:0]  RtE;
  logic [4:0]  RdE;
  logic [4:0]  ShamtE;

  int n_assert = 0;
  int n_fail   = 0;

  // model: instruction slot waiting in decode, and register contents
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_rf [32];

  logic [31:0] e_valid, e_pc, e_rsd, e_rtd, e_imm;
  logic [31:0] e_op, e_fn, e_rs, e_rt, e_rd, e_sh;

  decode_stage dut (
    .clk(clk), .reset(reset), .Inst(Inst), .PCNext(PCNext),
    .stall(stall), .flush(flush), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .ValidE(ValidE),
    .PCNextE(PCNextE), .RsDataE(RsDataE), .RtDataE(RtDataE),
    .ImmE(ImmE), .OpE(OpE), .FunctE(FunctE), .RsE(RsE),
    .RtE(RtE), .RdE(RdE), .ShamtE(ShamtE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 32'(ValidE), e_valid);
    chk({tag, ".pc"}, PCNextE, e_pc);
    chk({tag, ".rsd"}, RsDataE, e_rsd);
    chk({tag, ".rtd"}, RtDataE, e_rtd);
    chk({tag, ".imm"}, ImmE, e_imm);
    chk({tag, ".op"}, 32'(OpE), e_op);
    chk({tag, ".fn"}, 32'(FunctE), e_fn);
    chk({tag, ".rs"}, 32'(RsE), e_rs);
    chk({tag, ".rt"}, 32'(RtE), e_rt);
    chk({tag, ".rd"}, 32'(RdE), e_rd);
    chk({tag, ".sh"}, 32'(ShamtE), e_sh);
  endtask

  task automatic clear_exp();
    e_valid = 0; e_pc = 0; e_rsd = 0; e_rtd = 0; e_imm = 0;
    e_op = 0; e_fn = 0; e_rs = 0; e_rt = 0; e_rd = 0; e_sh = 0;
  endtask

  task automatic model_reset();
    m_inst = 0; m_pc = 0; m_valid = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    clear_exp();
  endtask

  function automatic logic [31:0] rd_reg(input logic [31:0] a);
    return (a == 0) ? 32'h0 : m_rf[a[4:0]];
  endfunction

  // one clock: drive, predict, clock, compare
  task automatic cyc(input string tag,
                     input logic [31:0] i, input logic [31:0] pc,
                     input logic st, input logic fl,
                     input logic we, input logic [4:0] wa,
                     input logic [31:0] wd);
    logic [31:0] imm16;
    Inst = i; PCNext = pc; stall = st; flush = fl;
    WrEn = we; WrAddr = wa; WrData = wd;
    // a same-edge write is visible to the read: apply it first
    if (we && wa != 0) m_rf[wa] = wd;
    clear_exp();
    if (!st) begin
      e_valid = {31'b0, m_valid};
      e_pc = m_pc;
      e_op = m_inst >> 26;
      e_rs = (m_inst >> 21) % 32;
      e_rt = (m_inst >> 16) % 32;
      e_rd = (m_inst >> 11) % 32;
      e_sh = (m_inst >> 6) % 32;
      e_fn = m_inst % 64;
      e_rsd = rd_reg(e_rs);
      e_rtd = rd_reg(e_rt);
      imm16 = m_inst % 65536;
      if (e_op >= 12 && e_op <= 14) e_imm = imm16;
      else if (e_op == 15) e_imm = imm16 * 65536;
      else if (imm16 >= 32768) e_imm = imm16 + 32'hFFFF0000;
      else e_imm = imm16;
    end
    if (fl) begin
      m_inst = 0; m_pc = 0; m_valid = 0;
    end else if (!st) begin
      m_inst = i; m_pc = pc; m_valid = 1;
    end
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic nop(input string tag);
    cyc(tag, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    logic [31:0] ri;
    reset = 1'b0;
    Inst = 0; PCNext = 0; stall = 0; flush = 0;
    WrEn = 0; WrAddr = 0; WrData = 0;
    model_reset();
    #12;
    chk_all("reset");
    reset = 1'b1;

    cyc("wr5", 32'h0, 32'h0, 0, 0, 1, 5'd5, 32'h12345678);
    cyc("add_in", 32'h00A63020, 32'h4, 0, 0, 0, 5'd0, 32'h0);
    nop("add_out");
    chk("add.rs", 32'(RsE), 32'd5);
    chk("add.rt", 32'(RtE), 32'd6);
    chk("add.rd", 32'(RdE), 32'd6);
    chk("add.fn", 32'(FunctE), 32'h20);
    chk("add.rsd", RsDataE, 32'h12345678);
    chk("add.rtd", RtDataE, 32'h0);
    chk("add.valid", 32'(ValidE), 32'd1);

    cyc("addi_in", 32'h2005FFFC, 32'h8, 0, 0, 0, 5'd0, 32'h0);
    cyc("ori_in", 32'h3405FFFC, 32'hC, 0, 0, 0, 5'd0, 32'h0);
    chk("addi.imm", ImmE, 32'hFFFFFFFC);
    cyc("lui_in", 32'h3C051234, 32'h10, 0, 0, 0, 5'd0, 32'h0);
    chk("ori.imm", ImmE, 32'h0000FFFC);
    nop("lui_out");
    chk("lui.imm", ImmE, 32'h12340000);

    cyc("byp_in", 32'h00E00020, 32'h14, 0, 0, 0, 5'd0, 32'h0);
    cyc("byp_wr", 32'h0, 32'h0, 0, 0, 1, 5'd7, 32'hCAFEF00D);
    chk("bypass.rsd", RsDataE, 32'hCAFEF00D);
    cyc("wr0", 32'h0, 32'h0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    cyc("r0_in", 32'h00000020, 32'h18, 0, 0, 0, 5'd0, 32'h0);
    nop("r0_out");
    chk("r0.rsd", RsDataE, 32'h0);

    cyc("stA", 32'h2005FFFC, 32'h100, 0, 0, 0, 5'd0, 32'h0);
    cyc("stall1", 32'h3405FFFC, 32'h104, 1, 0, 0, 5'd0, 32'h0);
    chk("stall1.valid", 32'(ValidE), 32'd0);
    cyc("stall2", 32'h3405FFFC, 32'h104, 1, 0, 0, 5'd0, 32'h0);
    chk("stall2.valid", 32'(ValidE), 32'd0);
    cyc("stA_out", 32'h3405FFFC, 32'h104, 0, 0, 0, 5'd0, 32'h0);
    chk("stA.pc", PCNextE, 32'h100);
    chk("stA.valid", 32'(ValidE), 32'd1);
    cyc("stB_out", 32'h3C051234, 32'h108, 0, 0, 0, 5'd0, 32'h0);
    chk("stB.pc", PCNextE, 32'h104);

    cyc("flX", 32'h00A63020, 32'h200, 0, 0, 0, 5'd0, 32'h0);
    cyc("flY", 32'h2005FFFC, 32'h204, 0, 0, 0, 5'd0, 32'h0);
    cyc("flush", 32'h3405FFFC, 32'h208, 0, 1, 0, 5'd0, 32'h0);
    chk("flush.keep_pc", PCNextE, 32'h204);
    cyc("flush_b", 32'h3C051234, 32'h20C, 0, 0, 0, 5'd0, 32'h0);
    chk("flush.bubble", 32'(ValidE), 32'd0);
    cyc("fsP", 32'h00A63020, 32'h300, 0, 0, 0, 5'd0, 32'h0);
    cyc("fsQ", 32'h2005FFFC, 32'h304, 1, 1, 0, 5'd0, 32'h0);
    cyc("fsR", 32'h3405FFFC, 32'h308, 0, 0, 0, 5'd0, 32'h0);
    chk("flst.bubble", 32'(ValidE), 32'd0);
    nop("fsR_out");
    chk("flst.next_pc", PCNextE, 32'h308);

    for (int k = 0; k < 300; k++) begin
      ri = $urandom;
      if ($urandom_range(0, 3) == 0)
        ri[31:26] = 6'($urandom_range(12, 15));
      cyc("rand", ri, $urandom,
          1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 1)),
          5'($urandom_range(0, 31)), $urandom);
    end

    cyc("pre_wr9", 32'h0, 32'h0, 0, 0, 1, 5'd9, 32'h5A5A5A5A);
    cyc("pre_rd9", 32'h01200020, 32'h400, 0, 0, 0, 5'd0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    WrEn = 1; WrAddr = 5'd9; WrData = 32'h77777777;
    @(posedge clk);
    #1;
    chk_all("rst_hold");
    reset = 1'b1;
    cyc("post_rd9", 32'h01200020, 32'h500, 0, 0, 0, 5'd0, 32'h0);
    nop("post_out");
    chk("post.rsd", RsDataE, 32'h0);
    chk("post.pc", PCNextE, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the processor, directly downstream of `fetch`. It latches the fetched instruction and its PC+4 into an IF/ID register, splits the instruction into MIPS-style fields, and reads two operands from a 32×32 register file. It registers everything into an ID/EX output register for the execute stage. Stall and flush controls support hazard handling, and a writeback port updates the register file.

## Interface
- Parameters: none; data width fixed at 32 bits, register address at 5 bits, 32 registers.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state while low.
- `Inst` in 32: instruction from `fetch`.
- `PCNext` in 32: PC+4 from `fetch`.
- `stall` in 1: hold IF/ID contents and insert a bubble into ID/EX.
- `flush` in 1: replace the IF/ID contents with a bubble (branch taken).
- `WrEn` in 1: register-file write enable (writeback).
- `WrAddr` in 5: register-file write address.
- `WrData` in 32: register-file write data.
- `ValidE` out 1: ID/EX slot holds a real instruction.
- `PCNextE` out 32: PC+4 of the instruction in ID/EX.
- `RsDataE`, `RtDataE` out 32: operand values read from the register file.
- `ImmE` out 32: extended 16-bit immediate.
- `OpE` out 6: opcode field, Inst[31:26].
- `FunctE` out 6: function field, Inst[5:0].
- `RsE`, `RtE`, `RdE` out 5: register specifiers.
- `ShamtE` out 5: shift amount, Inst[10:6].

## Operation
- IF/ID register holds InstD, PCNextD and ValidD.
  - Normal cycle: loads `Inst`, `PCNext`, ValidD=1.
  - `stall`=1: holds its contents.
  - `flush`=1: loads InstD=0 (NOP), PCNextD=0, ValidD=0.
  - `flush` and `stall` both 1: flush wins.
- Field split of InstD: Op=[31:26], Rs=[25:21], Rt=[20:16], Rd=[15:11], Shamt=[10:6], Funct=[5:0], Imm16=[15:0].
- Immediate extension:
  - Zero-extend when Op is 0x0C (andi), 0x0D (ori) or 0x0E (xori).
  - Load upper when Op is 0x0F (lui): ImmE = {Imm16, 16'h0}.
  - Sign-extend for every other opcode.
- Register file:
  - 32 entries of 32 bits, two combinational read ports addressed by Rs and Rt, one synchronous write port.
  - Register 0 always reads 0; writes to address 0 are ignored.
  - Write-through bypass: when WrEn=1, WrAddr≠0 and WrAddr equals a read address in the same cycle, that read returns `WrData`.
- ID/EX register:
  - Normal cycle: loads all decoded fields, operand values, PCNextD, and ValidE=ValidD.
  - `stall`=1: loads a bubble, with ValidE=0 and every other E output 0.
  - `flush` does not touch ID/EX; the instruction already in ID/EX proceeds.

## Timing
- Reset (`reset`=0, asynchronous):
  - IF/ID cleared (InstD=0, ValidD=0).
  - Every E output is 0, including ValidE.
  - Every register-file entry is 0.
  - Takes effect without waiting for a clock edge, including mid-stall or mid-write; a write in the same cycle as reset is lost.
- Latency: `Inst` sampled at edge N appears decoded on the E outputs after edge N+1, i.e. 2 edges from fetch output to E outputs.
- A register-file write at edge N is visible to a read at edge N via the bypass, and from the array after N.
- A stall held for k cycles produces k bubbles in ID/EX. The held instruction is issued on the first edge after `stall` falls, with no loss and no duplication.
- A flush at edge N makes ID/EX receive a bubble at edge N+1.

## Test plan
- Reset and write/read: hold `reset`=0 and confirm every E output is 0. Release, write R5=0x12345678, then feed Inst=0x00A63020 (add $6,$5,$6); two edges later RsE=5, RtE=6, RdE=6, FunctE=0x20, RsDataE=0x12345678, RtDataE=0, ValidE=1.
- Immediates:
  - Inst=0x2005FFFC (addi): ImmE=0xFFFFFFFC.
  - Inst=0x3405FFFC (ori): ImmE=0x0000FFFC.
  - Inst=0x3C051234 (lui): ImmE=0x12340000.
- Bypass and $0: write R7=0xCAFEF00D in the same cycle decode reads Rs=7 → RsDataE=0xCAFEF00D. Write R0=0xFFFFFFFF, then read Rs=0 → 0.
- Stall: assert `stall` for 2 cycles while instruction A sits in IF/ID → two bubbles (ValidE=0), then A appears once with its PCNextE intact; the following instruction B appears next.
- Flush and priority: assert `flush` alone → next ID/EX slot ValidE=0 and the instruction in ID/EX completes. Assert `flush` and `stall` together → IF/ID cleared to a bubble, not held.
- Asynchronous reset mid-run: drop `reset` between clock edges → E outputs and the register file read 0 immediately, before the next edge.
